// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// The state encoding and the default abort timeout live here so every block agrees on them.
package mem_ctrl_pkg;

    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int CNT_W           = 8;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } mem_state_e;

    // Word accesses only: both low address bits must be zero.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Wait-cycle counter for an outstanding memory request.
// Flags when the count sits at the abort limit; the controller decides what that means.
import mem_ctrl_pkg::*;

module mem_timeout_counter (
    input  logic             clk,
    input  logic             Reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             hit_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == limit_i);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: turns EX/MEM load/store requests into a
// req/ready handshake, stalls the pipeline while waiting, and aborts on misuse or timeout.
import mem_ctrl_pkg::*;

module mem_access_ctrl #(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              MemRead_EX_MEM,
    input  logic              MemWrite_EX_MEM,
    input  logic [ADDR_W-1:0] ALU_OUT_EX_MEM,
    input  logic [DATA_W-1:0] Data_Memory_Input_EX_MEM,
    input  logic              DMem_Ready,
    input  logic [DATA_W-1:0] DMem_RData,
    output logic              DMem_Req,
    output logic              DMem_WE,
    output logic [ADDR_W-1:0] DMem_Addr,
    output logic [DATA_W-1:0] DMem_WData,
    output logic              Stall_MEM,
    output logic [DATA_W-1:0] Mem_Data_Out,
    output logic              Mem_Valid,
    output logic              Mem_Error
);

    // Counter value on the last REQ cycle allowed before the access is aborted.
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;

    logic cnt_clr;
    logic cnt_en;
    logic cnt_hit;

    logic req_any;
    logic req_bad;
    logic req_ok;

    assign req_any = MemRead_EX_MEM | MemWrite_EX_MEM;
    assign req_bad = (MemRead_EX_MEM & MemWrite_EX_MEM) |
                     (req_any & ~is_word_aligned(ALU_OUT_EX_MEM[1:0]));
    assign req_ok  = req_any & ~req_bad;

    mem_timeout_counter u_wait_cnt (
        .clk     (clk),
        .Reset   (Reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (WAIT_LIMIT),
        .hit_o   (cnt_hit)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        we_d      = we_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        DMem_Req  = 1'b0;
        DMem_WE   = 1'b0;
        Stall_MEM = 1'b0;
        Mem_Valid = 1'b0;
        Mem_Error = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_bad) begin
                    state_d = ST_ERROR;
                end else if (req_ok) begin
                    state_d   = ST_REQ;
                    addr_d    = ALU_OUT_EX_MEM;
                    wdata_d   = Data_Memory_Input_EX_MEM;
                    we_d      = MemWrite_EX_MEM;
                    cnt_clr   = 1'b1;
                    Stall_MEM = 1'b1;
                end
            end
            ST_REQ: begin
                DMem_Req  = 1'b1;
                DMem_WE   = we_q;
                Stall_MEM = 1'b1;
                // Ready beats the timeout when both land in the same cycle.
                if (DMem_Ready) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        rdata_d = DMem_RData;
                    end
                end else if (cnt_hit) begin
                    state_d = ST_ERROR;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_DONE: begin
                Mem_Valid = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_ERROR: begin
                Mem_Error = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
        end
    end

    assign DMem_Addr    = addr_q;
    assign DMem_WData   = wdata_q;
    assign Mem_Data_Out = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl built with a 4-cycle timeout; expected values are hand-derived.
`timescale 1ns/1ps
module tb_mem_access_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        Reset;
    logic        MemRead_EX_MEM;
    logic        MemWrite_EX_MEM;
    logic [31:0] ALU_OUT_EX_MEM;
    logic [31:0] Data_Memory_Input_EX_MEM;
    logic        DMem_Ready;
    logic [31:0] DMem_RData;
    logic        DMem_Req;
    logic        DMem_WE;
    logic [31:0] DMem_Addr;
    logic [31:0] DMem_WData;
    logic        Stall_MEM;
    logic [31:0] Mem_Data_Out;
    logic        Mem_Valid;
    logic        Mem_Error;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk                      (clk),
        .Reset                    (Reset),
        .MemRead_EX_MEM           (MemRead_EX_MEM),
        .MemWrite_EX_MEM          (MemWrite_EX_MEM),
        .ALU_OUT_EX_MEM           (ALU_OUT_EX_MEM),
        .Data_Memory_Input_EX_MEM (Data_Memory_Input_EX_MEM),
        .DMem_Ready               (DMem_Ready),
        .DMem_RData               (DMem_RData),
        .DMem_Req                 (DMem_Req),
        .DMem_WE                  (DMem_WE),
        .DMem_Addr                (DMem_Addr),
        .DMem_WData               (DMem_WData),
        .Stall_MEM                (Stall_MEM),
        .Mem_Data_Out             (Mem_Data_Out),
        .Mem_Valid                (Mem_Valid),
        .Mem_Error                (Mem_Error)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Advance to 1ns after the next rising edge; inputs are driven here, outputs checked 2ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MemRead_EX_MEM = 1'b0;
        MemWrite_EX_MEM = 1'b0;
        ALU_OUT_EX_MEM = 32'h0;
        Data_Memory_Input_EX_MEM = 32'h0;
        DMem_Ready = 1'b0;
        DMem_RData = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        #2;
        n_cmp++; if (DMem_Req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b expected 0", DMem_Req); end
        n_cmp++; if (DMem_WE !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b expected 0", DMem_WE); end
        n_cmp++; if (Stall_MEM !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b expected 0", Stall_MEM); end
        n_cmp++; if (Mem_Valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b expected 0", Mem_Valid); end
        n_cmp++; if (Mem_Error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b expected 0", Mem_Error); end
        n_cmp++; if (DMem_Addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h expected 0", DMem_Addr); end
        n_cmp++; if (DMem_WData !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h expected 0", DMem_WData); end
        n_cmp++; if (Mem_Data_Out !== 32'h0) begin n_bad++; $display("FAIL rst_dout: got %h expected 0", Mem_Data_Out); end
        step();
    endtask

    task automatic test_load();
        int stall_cnt = 0;
        MemRead_EX_MEM = 1'b1;
        ALU_OUT_EX_MEM = 32'h0000_0010;
        #2;
        stall_cnt += int'(Stall_MEM);
        n_cmp++; if (DMem_Req !== 1'b0) begin n_bad++; $display("FAIL load_idle_req: got %b expected 0", DMem_Req); end
        step();
        DMem_Ready = 1'b1;
        DMem_RData = 32'hDEAD_BEEF;
        #2;
        stall_cnt += int'(Stall_MEM);
        n_cmp++; if (DMem_Req !== 1'b1) begin n_bad++; $display("FAIL load_req: got %b expected 1", DMem_Req); end
        n_cmp++; if (DMem_WE !== 1'b0) begin n_bad++; $display("FAIL load_we: got %b expected 0", DMem_WE); end
        n_cmp++; if (DMem_Addr !== 32'h0000_0010) begin n_bad++; $display("FAIL load_addr: got %h expected 00000010", DMem_Addr); end
        step();
        DMem_Ready = 1'b0;
        DMem_RData = 32'h0;
        MemRead_EX_MEM = 1'b0;
        ALU_OUT_EX_MEM = 32'h0;
        #2;
        stall_cnt += int'(Stall_MEM);
        n_cmp++; if (Mem_Valid !== 1'b1) begin n_bad++; $display("FAIL load_valid: got %b expected 1", Mem_Valid); end
        n_cmp++; if (Mem_Data_Out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL load_dout: got %h expected deadbeef", Mem_Data_Out); end
        n_cmp++; if (DMem_Req !== 1'b0) begin n_bad++; $display("FAIL load_done_req: got %b expected 0", DMem_Req); end
        n_cmp++; if (stall_cnt !== 2) begin n_bad++; $display("FAIL load_stall_cycles: got %0d expected 2", stall_cnt); end
        step();
        #2;
        n_cmp++; if (Mem_Valid !== 1'b0) begin n_bad++; $display("FAIL load_valid_pulse: got %b expected 0", Mem_Valid); end
    endtask

    task automatic test_store();
        MemWrite_EX_MEM = 1'b1;
        ALU_OUT_EX_MEM = 32'h0000_0020;
        Data_Memory_Input_EX_MEM = 32'h1234_5678;
        #2;
        n_cmp++; if (Stall_MEM !== 1'b1) begin n_bad++; $display("FAIL st_idle_stall: got %b expected 1", Stall_MEM); end
        step();
        for (int i = 0; i < 4; i++) begin
            DMem_Ready = (i == 3);
            DMem_RData = 32'hBAD0_BAD0;
            #2;
            n_cmp++; if (DMem_WE !== 1'b1) begin n_bad++; $display("FAIL st_we[%0d]: got %b expected 1", i, DMem_WE); end
            n_cmp++; if (DMem_Addr !== 32'h0000_0020) begin n_bad++; $display("FAIL st_addr[%0d]: got %h expected 00000020", i, DMem_Addr); end
            n_cmp++; if (DMem_WData !== 32'h1234_5678) begin n_bad++; $display("FAIL st_wdata[%0d]: got %h expected 12345678", i, DMem_WData); end
            n_cmp++; if (Stall_MEM !== 1'b1) begin n_bad++; $display("FAIL st_stall[%0d]: got %b expected 1", i, Stall_MEM); end
            step();
        end
        DMem_Ready = 1'b0;
        MemWrite_EX_MEM = 1'b0;
        #2;
        n_cmp++; if (Mem_Valid !== 1'b1) begin n_bad++; $display("FAIL st_valid: got %b expected 1", Mem_Valid); end
        n_cmp++; if (Mem_Error !== 1'b0) begin n_bad++; $display("FAIL st_error: got %b expected 0", Mem_Error); end
        n_cmp++; if (Mem_Data_Out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL st_dout: got %h expected deadbeef", Mem_Data_Out); end
        n_cmp++; if (DMem_WE !== 1'b0) begin n_bad++; $display("FAIL st_done_we: got %b expected 0", DMem_WE); end
        step();
        idle_inputs();
    endtask

    // Illegal request: error pulse one cycle later, never a request or stall.
    task automatic run_illegal(input string name, input logic rd, input logic wr, input logic [31:0] addr);
        MemRead_EX_MEM = rd;
        MemWrite_EX_MEM = wr;
        ALU_OUT_EX_MEM = addr;
        #2;
        n_cmp++; if (Stall_MEM !== 1'b0) begin n_bad++; $display("FAIL %s_stall: got %b expected 0", name, Stall_MEM); end
        n_cmp++; if (DMem_Req !== 1'b0) begin n_bad++; $display("FAIL %s_req: got %b expected 0", name, DMem_Req); end
        step();
        idle_inputs();
        #2;
        n_cmp++; if (Mem_Error !== 1'b1) begin n_bad++; $display("FAIL %s_error: got %b expected 1", name, Mem_Error); end
        n_cmp++; if (DMem_Req !== 1'b0) begin n_bad++; $display("FAIL %s_err_req: got %b expected 0", name, DMem_Req); end
        n_cmp++; if (Stall_MEM !== 1'b0) begin n_bad++; $display("FAIL %s_err_stall: got %b expected 0", name, Stall_MEM); end
        n_cmp++; if (Mem_Valid !== 1'b0) begin n_bad++; $display("FAIL %s_valid: got %b expected 0", name, Mem_Valid); end
        step();
        #2;
        n_cmp++; if (Mem_Error !== 1'b0) begin n_bad++; $display("FAIL %s_err_pulse: got %b expected 0", name, Mem_Error); end
    endtask

    task automatic test_illegal();
        run_illegal("misalign_ld", 1'b1, 1'b0, 32'h0000_0013);
        step();
        run_illegal("misalign_st", 1'b0, 1'b1, 32'h0000_0022);
        step();
        run_illegal("conflict", 1'b1, 1'b1, 32'h0000_0040);
        step();
    endtask

    task automatic test_timeout();
        int req_cnt = 0;
        MemRead_EX_MEM = 1'b1;
        ALU_OUT_EX_MEM = 32'h0000_0030;
        step();
        for (int i = 0; i < TMO; i++) begin
            #2;
            req_cnt += int'(DMem_Req);
            n_cmp++; if (Mem_Error !== 1'b0) begin n_bad++; $display("FAIL tmo_early_err[%0d]: got %b expected 0", i, Mem_Error); end
            step();
        end
        MemRead_EX_MEM = 1'b0;
        #2;
        n_cmp++; if (req_cnt !== TMO) begin n_bad++; $display("FAIL tmo_req_cycles: got %0d expected %0d", req_cnt, TMO); end
        n_cmp++; if (Mem_Error !== 1'b1) begin n_bad++; $display("FAIL tmo_error: got %b expected 1", Mem_Error); end
        n_cmp++; if (DMem_Req !== 1'b0) begin n_bad++; $display("FAIL tmo_req_off: got %b expected 0", DMem_Req); end
        n_cmp++; if (Mem_Data_Out !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL tmo_dout: got %h expected deadbeef", Mem_Data_Out); end
        step();
        #2;
        n_cmp++; if (Mem_Error !== 1'b0) begin n_bad++; $display("FAIL tmo_err_pulse: got %b expected 0", Mem_Error); end
        n_cmp++; if (Stall_MEM !== 1'b0) begin n_bad++; $display("FAIL tmo_idle_stall: got %b expected 0", Stall_MEM); end
        idle_inputs();
        step();
    endtask

    task automatic test_ready_at_limit();
        MemRead_EX_MEM = 1'b1;
        ALU_OUT_EX_MEM = 32'h0000_0034;
        step();
        for (int i = 0; i < TMO; i++) begin
            DMem_Ready = (i == TMO - 1);
            DMem_RData = 32'hCAFE_F00D;
            #2;
            n_cmp++; if (DMem_Req !== 1'b1) begin n_bad++; $display("FAIL lim_req[%0d]: got %b expected 1", i, DMem_Req); end
            step();
        end
        idle_inputs();
        #2;
        n_cmp++; if (Mem_Valid !== 1'b1) begin n_bad++; $display("FAIL lim_valid: got %b expected 1", Mem_Valid); end
        n_cmp++; if (Mem_Error !== 1'b0) begin n_bad++; $display("FAIL lim_error: got %b expected 0", Mem_Error); end
        n_cmp++; if (Mem_Data_Out !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL lim_dout: got %h expected cafef00d", Mem_Data_Out); end
        step();
        #2;
        n_cmp++; if (Mem_Error !== 1'b0) begin n_bad++; $display("FAIL lim_late_error: got %b expected 0", Mem_Error); end
    endtask

    task automatic test_back_to_back();
        MemRead_EX_MEM = 1'b1;
        ALU_OUT_EX_MEM = 32'h0000_0048;
        step();
        DMem_Ready = 1'b1;
        DMem_RData = 32'hAAAA_5555;
        step();
        // Next request is already present while the first one is in DONE.
        DMem_Ready = 1'b0;
        ALU_OUT_EX_MEM = 32'h0000_0050;
        #2;
        n_cmp++; if (Mem_Valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid1: got %b expected 1", Mem_Valid); end
        n_cmp++; if (Stall_MEM !== 1'b0) begin n_bad++; $display("FAIL b2b_done_stall: got %b expected 0", Stall_MEM); end
        n_cmp++; if (Mem_Data_Out !== 32'hAAAA_5555) begin n_bad++; $display("FAIL b2b_dout1: got %h expected aaaa5555", Mem_Data_Out); end
        step();
        #2;
        n_cmp++; if (Stall_MEM !== 1'b1) begin n_bad++; $display("FAIL b2b_idle_stall: got %b expected 1", Stall_MEM); end
        n_cmp++; if (DMem_Req !== 1'b0) begin n_bad++; $display("FAIL b2b_idle_req: got %b expected 0", DMem_Req); end
        step();
        DMem_Ready = 1'b1;
        DMem_RData = 32'h1111_2222;
        #2;
        n_cmp++; if (DMem_Addr !== 32'h0000_0050) begin n_bad++; $display("FAIL b2b_addr2: got %h expected 00000050", DMem_Addr); end
        step();
        idle_inputs();
        #2;
        n_cmp++; if (Mem_Data_Out !== 32'h1111_2222) begin n_bad++; $display("FAIL b2b_dout2: got %h expected 11112222", Mem_Data_Out); end
        step();
    endtask

    task automatic test_reset_in_req();
        int pulse_cnt = 0;
        MemRead_EX_MEM = 1'b1;
        ALU_OUT_EX_MEM = 32'h0000_0060;
        Data_Memory_Input_EX_MEM = 32'h7777_8888;
        step();
        step();
        Reset = 1'b1;
        DMem_Ready = 1'b1;
        DMem_RData = 32'h5A5A_5A5A;
        #2;
        n_cmp++; if (DMem_Req !== 1'b1) begin n_bad++; $display("FAIL rreq_req2: got %b expected 1", DMem_Req); end
        step();
        Reset = 1'b0;
        idle_inputs();
        #2;
        pulse_cnt += int'(Mem_Valid) + int'(Mem_Error);
        n_cmp++; if (DMem_Req !== 1'b0) begin n_bad++; $display("FAIL rreq_req_off: got %b expected 0", DMem_Req); end
        n_cmp++; if (Stall_MEM !== 1'b0) begin n_bad++; $display("FAIL rreq_stall: got %b expected 0", Stall_MEM); end
        n_cmp++; if (DMem_Addr !== 32'h0) begin n_bad++; $display("FAIL rreq_addr: got %h expected 0", DMem_Addr); end
        n_cmp++; if (Mem_Data_Out !== 32'h0) begin n_bad++; $display("FAIL rreq_dout: got %h expected 0", Mem_Data_Out); end
        step();
        #2;
        pulse_cnt += int'(Mem_Valid) + int'(Mem_Error);
        step();
        #2;
        pulse_cnt += int'(Mem_Valid) + int'(Mem_Error) + int'(DMem_Req);
        n_cmp++; if (pulse_cnt !== 0) begin n_bad++; $display("FAIL rreq_pulses: got %0d expected 0", pulse_cnt); end
    endtask

    initial begin
        Reset = 1'b1;
        idle_inputs();
        test_reset();
        test_load();
        step();
        test_store();
        test_illegal();
        test_timeout();
        test_ready_at_limit();
        step();
        test_back_to_back();
        test_reset_in_req();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, SHALL set the number of REQ-state cycles without DMem_Ready before an access is aborted; legal range 1..255.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-003 Reset  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 MemRead_EX_MEM  input  1  SHALL be the load request from the EX/MEM stage.
REQ-005 MemWrite_EX_MEM  input  1  SHALL be the store request from the EX/MEM stage.
REQ-006 ALU_OUT_EX_MEM  input  32  SHALL be the byte address of the access.
REQ-007 Data_Memory_Input_EX_MEM  input  32  SHALL be the store data.
REQ-008 DMem_Ready  input  1  SHALL be the memory completion strobe; ignored outside state REQ.
REQ-009 DMem_RData  input  32  SHALL be the read data, valid when DMem_Ready=1.
REQ-010 DMem_Req  output  1  SHALL be the memory request, high throughout state REQ only.
REQ-011 DMem_WE  output  1  SHALL be the write enable, high in REQ for stores only.
REQ-012 DMem_Addr, DMem_WData  output  32 each  SHALL be the latched address and store data.
REQ-013 Stall_MEM  output  1  SHALL hold the EX/MEM register and upstream stages.
REQ-014 Mem_Data_Out  output  32  SHALL be the last completed load data.
REQ-015 Mem_Valid  output  1  SHALL pulse for one cycle on successful completion.
REQ-016 Mem_Error  output  1  SHALL pulse for one cycle on misalignment, conflict or timeout.

Function
REQ-017 FSM states SHALL be IDLE, REQ, DONE, ERROR.
REQ-018 In IDLE, when MemRead_EX_MEM and MemWrite_EX_MEM are both high, or either is high with ALU_OUT_EX_MEM[1:0]!=0, the next state SHALL be ERROR, with no request issued.
REQ-019 In IDLE, for a single aligned request, the block SHALL latch address, store data and WE, and the next state SHALL be REQ.
REQ-020 Stall_MEM SHALL be combinational: high in IDLE when a legal request is present, and high in REQ; low in DONE, ERROR and idle-without-request.
REQ-021 In REQ, DMem_Ready=1 SHALL cause transition to DONE; for loads DMem_RData SHALL be captured into Mem_Data_Out on that edge.
REQ-022 An 8-bit wait counter SHALL clear on REQ entry and increment each REQ cycle without DMem_Ready; when it reaches TIMEOUT_CYCLES-1 without DMem_Ready the next state SHALL be ERROR.
REQ-023 DMem_Ready in the same cycle the counter reaches its limit SHALL win: the next state is DONE.
REQ-024 DONE SHALL assert Mem_Valid for one cycle and go to IDLE; ERROR SHALL assert Mem_Error for one cycle and go to IDLE.
REQ-025 Minimum load latency SHALL be 3 cycles (IDLE detect -> REQ with Ready -> DONE, data valid in DONE).
REQ-026 Back-to-back accesses SHALL each pass through IDLE; the next request is evaluated in the cycle after DONE/ERROR.
REQ-027 Stores SHALL leave Mem_Data_Out unchanged; DMem_Addr/DMem_WData SHALL remain stable throughout REQ.

Reset
REQ-028 Reset=1 at a rising edge SHALL force state IDLE, counter 0, and DMem_Req, DMem_WE, Mem_Valid, Mem_Error, Stall_MEM low; DMem_Addr, DMem_WData and Mem_Data_Out SHALL be 0.
REQ-029 Reset during REQ SHALL abandon the access: DMem_Req low from the next cycle, no Mem_Valid or Mem_Error pulse.

Structure
REQ-030 State encoding and the TIMEOUT_CYCLES default SHALL live in the shared package mem_ctrl_pkg.
REQ-031 The wait counter SHALL be one sub-module, mem_timeout_counter, with clear, enable and limit-hit ports.

Verification
REQ-032 Load to 0x0000_0010, Ready on first REQ cycle with RData=0xDEAD_BEEF -> Stall high 2 cycles, Mem_Valid in cycle 3, Mem_Data_Out=0xDEAD_BEEF.
REQ-033 Store 0x1234_5678 to 0x0000_0020, Ready after 4 REQ cycles -> DMem_WE=1 and Addr/WData stable 4 cycles, Mem_Valid pulse, Mem_Data_Out unchanged.
REQ-034 Load to 0x0000_0013 -> Mem_Error one cycle later, DMem_Req never high, Stall_MEM never high.
REQ-035 TIMEOUT_CYCLES=4, Ready held low -> DMem_Req high 4 cycles, Mem_Error pulse, back to IDLE; repeat with Ready on the 4th cycle -> Mem_Valid, no error.
REQ-036 Reset asserted on the 2nd REQ cycle -> DMem_Req low next cycle, all outputs at reset values, no Mem_Valid/Mem_Error.
